tlb_walker: RTL and testbench

//  Responder side of the TLB miss interface: accepts one translation miss (VPN + PCID)
//  and performs a multi-level page-table walk via a single-outstanding memory read port.

---
 rtl/tlb_pkg.sv | 35 +++
 rtl/tlb_pte_decode.sv | 45 ++++
 rtl/tlb_walker.sv | 182 ++++++++++++++++++
 tb/tb_tlb_walker.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// ---------------------------------------------------------------------------
// tlb_pkg
// Shared definitions for the TLB miss walker.
//   - Default address, page, PCID and VPN widths.
//   - PTE flag bit positions: PTE_V (valid) and PTE_LEAF (leaf entry).
//   - Walker state enum.
//   - Fill result struct returned to the TLB set array.
// ---------------------------------------------------------------------------
package tlb_pkg;

    localparam int ADDR_W = 64;
    localparam int PAGE_W = 12;
    localparam int PCID_W = 12;
    localparam int VPN_W  = ADDR_W - PAGE_W;

    // Flag positions inside a page-table entry
    localparam int PTE_V    = 0;
    localparam int PTE_LEAF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } walk_state_e;

    // Result handed back to the TLB; ppn is forced to zero on a fault
    typedef struct packed {
        logic [VPN_W-1:0]  vpn;
        logic [PCID_W-1:0] pcid;
        logic [VPN_W-1:0]  ppn;
        logic              fault;
    } fill_t;

endpackage

// File: rtl/tlb_pte_decode.sv
// ---------------------------------------------------------------------------
// tlb_pte_decode
// Combinational classification of one returned page-table entry.
// Ports:
//   pte         in   PTE_W       raw entry from memory
//   level_zero  in   1           entry was read at the last (leaf) level
//   ppn         out  ADDR-PAGE   PPN field of the entry
//   fault       out  1           entry ends the walk with a fault
//   leaf_hit    out  1           valid leaf at level 0, walk completes
//   descend     out  1           valid pointer above level 0, walk continues
// Exactly one of fault / leaf_hit / descend is high for any input.
// ---------------------------------------------------------------------------
module tlb_pte_decode
    import tlb_pkg::*;
#(
    parameter int ADDR  = 64,
    parameter int PAGE  = 12,
    parameter int PTE_W = 64
) (
    input  logic [PTE_W-1:0]     pte,
    input  logic                 level_zero,
    output logic [ADDR-PAGE-1:0] ppn,
    output logic                 fault,
    output logic                 leaf_hit,
    output logic                 descend
);

    logic pte_valid;
    logic pte_leaf;
    logic unused_bits;

    assign pte_valid = pte[PTE_V];
    assign pte_leaf  = pte[PTE_LEAF];
    assign ppn       = pte[ADDR-1:PAGE];

    // Software-defined bits between the flags and the PPN are not interpreted
    assign unused_bits = ^pte[PAGE-1:PTE_LEAF+1];

    // Superpages are not supported, so a leaf above level 0 is a fault, and a
    // pointer at level 0 has nowhere left to point.
    assign leaf_hit = pte_valid &&  pte_leaf &&  level_zero;
    assign descend  = pte_valid && !pte_leaf && !level_zero;
    assign fault    = !leaf_hit && !descend;

endmodule

// File: rtl/tlb_walker.sv
// ---------------------------------------------------------------------------
// tlb_walker
// Responder side of the TLB miss interface. Accepts one miss (VPN + PCID),
// walks a LEVELS-deep page table through a single-outstanding read port and
// returns a fill (PPN or fault) to the TLB set array.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   root_ppn       in   ADDR-PAGE top-level table PPN, sampled at accept
//   miss_valid     in   1         miss request
//   miss_ready     out  1         high only while idle
//   miss_vpn       in   ADDR-PAGE missing virtual page number
//   miss_pcid      in   PCID_B    PCID of the miss
//   mem_req_valid  out  1         PTE read request
//   mem_req_ready  in   1         memory accepts request
//   mem_req_addr   out  ADDR      byte address of the PTE
//   mem_rsp_valid  in   1         PTE data returned
//   mem_rsp_data   in   PTE_W     PTE (bit0 V, bit1 LEAF, [ADDR-1:PAGE] PPN)
//   fill_valid     out  1         fill result valid
//   fill_ready     in   1         TLB consumes fill
//   fill_vpn       out  ADDR-PAGE echoed VPN
//   fill_pcid      out  PCID_B    echoed PCID
//   fill_ppn       out  ADDR-PAGE translated PPN, 0 on fault
//   fill_fault     out  1         walk failed
// ---------------------------------------------------------------------------
module tlb_walker
    import tlb_pkg::*;
#(
    parameter int ADDR   = 64,
    parameter int PAGE   = 12,
    parameter int PCID_B = 12,
    parameter int LEVELS = 4,
    parameter int IDX_B  = 9,
    parameter int PTE_W  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR-PAGE-1:0] root_ppn,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  logic [ADDR-PAGE-1:0] miss_vpn,
    input  logic [PCID_B-1:0]    miss_pcid,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR-1:0]      mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [PTE_W-1:0]     mem_rsp_data,
    output logic                 fill_valid,
    input  logic                 fill_ready,
    output logic [ADDR-PAGE-1:0] fill_vpn,
    output logic [PCID_B-1:0]    fill_pcid,
    output logic [ADDR-PAGE-1:0] fill_ppn,
    output logic                 fill_fault
);

    localparam int VPN_BITS = ADDR - PAGE;
    localparam int VA_MSB   = LEVELS * IDX_B - 1;
    localparam int LVL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int OFF_W    = PAGE - IDX_B;

    walk_state_e state_q;
    walk_state_e state_d;

    logic [VPN_BITS-1:0] table_ppn_q;
    logic [LVL_W-1:0]    level_q;
    fill_t               fill_q;

    logic                accept;
    logic                rsp_take;
    logic                noncanon;
    logic [VPN_BITS-1:VA_MSB] vpn_high;
    logic [IDX_B-1:0]    req_idx;

    logic [VPN_BITS-1:0] pte_ppn;
    logic                pte_fault;
    logic                pte_leaf_hit;
    logic                pte_descend;

    assign accept   = (state_q == ST_IDLE) && miss_valid;
    assign rsp_take = (state_q == ST_WAIT) && mem_rsp_valid;

    // A VPN is canonical when every bit above the walked range copies the top
    // walked bit, i.e. the slice including that bit is all zeros or all ones.
    assign vpn_high = miss_vpn[VPN_BITS-1:VA_MSB];
    assign noncanon = (vpn_high != '0) && (vpn_high != '1);

    // Index of the current level, taken from the latched VPN
    assign req_idx = IDX_B'(fill_q.vpn >> (IDX_B * int'(level_q)));

    tlb_pte_decode #(
        .ADDR  (ADDR),
        .PAGE  (PAGE),
        .PTE_W (PTE_W)
    ) u_decode (
        .pte        (mem_rsp_data),
        .level_zero (level_q == '0),
        .ppn        (pte_ppn),
        .fault      (pte_fault),
        .leaf_hit   (pte_leaf_hit),
        .descend    (pte_descend)
    );

    // State register; reset abandons any walk in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a non-canonical miss skips memory entirely, and a
    // response is only looked at while a request is outstanding.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_valid) begin
                    state_d = noncanon ? ST_FILL : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = pte_descend ? ST_REQ : ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Walk datapath: latch the miss on accept, then either step down one level
    // or record the final translation / fault when a PTE comes back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_ppn_q <= '0;
            level_q     <= '0;
            fill_q      <= '0;
        end else if (accept) begin
            table_ppn_q  <= root_ppn;
            level_q      <= LVL_W'(LEVELS - 1);
            fill_q.vpn   <= miss_vpn;
            fill_q.pcid  <= miss_pcid;
            fill_q.ppn   <= '0;
            fill_q.fault <= noncanon;
        end else if (rsp_take) begin
            if (pte_descend) begin
                table_ppn_q <= pte_ppn;
                level_q     <= level_q - 1'b1;
            end else if (pte_leaf_hit) begin
                fill_q.ppn <= pte_ppn;
            end else if (pte_fault) begin
                fill_q.fault <= 1'b1;
            end
        end
    end

    // Outputs are decoded from the state; the request address is only driven
    // while a request is being presented.
    always_comb begin
        miss_ready    = (state_q == ST_IDLE);
        mem_req_valid = (state_q == ST_REQ);
        mem_req_addr  = '0;
        if (state_q == ST_REQ) begin
            mem_req_addr = {table_ppn_q, req_idx, {OFF_W{1'b0}}};
        end
        fill_valid = (state_q == ST_FILL);
        fill_vpn   = fill_q.vpn;
        fill_pcid  = fill_q.pcid;
        fill_ppn   = fill_q.ppn;
        fill_fault = fill_q.fault;
    end

endmodule

// File: tb/tb_tlb_walker.sv
// ---------------------------------------------------------------------------
// tb_tlb_walker
// Self-checking bench for tlb_walker: directed walks plus randomized page
// tables checked against a behavioural walk model.
// ---------------------------------------------------------------------------
module tb_tlb_walker;

    logic        clk;
    logic        rst;
    logic [51:0] root_ppn;
    logic        miss_valid;
    logic        miss_ready;
    logic [51:0] miss_vpn;
    logic [11:0] miss_pcid;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        fill_valid;
    logic        fill_ready;
    logic [51:0] fill_vpn;
    logic [11:0] fill_pcid;
    logic [51:0] fill_ppn;
    logic        fill_fault;

    int errors = 0;
    int checks = 0;

    // Sparse backing memory for page tables
    logic [63:0] mem [logic [63:0]];

    // Model expectations
    logic [51:0] exp_ppn;
    logic        exp_fault;
    logic [63:0] exp_addrs [$];

    // Observations collected by the walk driver
    logic [63:0] obs_addrs [$];
    int          obs_latency;
    logic        obs_timeout;
    logic        obs_unstable;
    logic [51:0] obs_vpn;
    logic [11:0] obs_pcid;
    logic [51:0] obs_ppn;
    logic        obs_fault;

    tlb_walker dut (
        .clk           (clk),
        .rst           (rst),
        .root_ppn      (root_ppn),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_vpn      (miss_vpn),
        .miss_pcid     (miss_pcid),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_vpn      (fill_vpn),
        .fill_pcid     (fill_pcid),
        .fill_ppn      (fill_ppn),
        .fill_fault    (fill_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'h0;
    endfunction

    // Reference walk: sign-extension check on the 36-bit virtual range, then
    // table walk with byte address = table_ppn*4096 + index*8.
    task automatic model_walk(input logic [51:0] vpn, input logic [51:0] root);
        logic [51:0] tbl;
        logic [63:0] a;
        logic [63:0] pte;
        logic [16:0] top;
        longint unsigned idx;
        exp_addrs.delete();
        exp_ppn   = '0;
        exp_fault = 1'b0;
        top = vpn[51:35];
        if (top != 17'h0 && top != 17'h1ffff) begin
            exp_fault = 1'b1;
            return;
        end
        tbl = root;
        for (int lvl = 3; lvl >= 0; lvl--) begin
            idx = longint'(vpn >> (9 * lvl)) % 512;
            a = {tbl, 12'h000} + 64'(idx * 8);
            exp_addrs.push_back(a);
            pte = mem_read(a);
            if (pte[0] == 1'b0) begin
                exp_fault = 1'b1;
                return;
            end
            if (pte[1] == 1'b1) begin
                if (lvl == 0) exp_ppn = pte[63:12];
                else exp_fault = 1'b1;
                return;
            end
            if (lvl == 0) begin
                exp_fault = 1'b1;
                return;
            end
            tbl = pte[63:12];
        end
    endtask

    // Drives one miss and serves its requests from mem; stops when fill_valid
    // is seen, leaving the fill pending.
    task automatic applyStimulus(input logic [51:0] vpn, input logic [11:0] pcid,
                                 input logic [51:0] root, input int req_stall);
        int n;
        int stall;
        logic [63:0] cur;
        obs_addrs.delete();
        obs_unstable = 1'b0;
        cur = '0;
        miss_vpn   = vpn;
        miss_pcid  = pcid;
        root_ppn   = root;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        n = 1;
        stall = 0;
        while (!fill_valid && n < 400) begin
            if (mem_req_valid) begin
                if (stall == 0) begin
                    obs_addrs.push_back(mem_req_addr);
                    cur = mem_req_addr;
                end else if (mem_req_addr !== cur) begin
                    obs_unstable = 1'b1;
                end
                if (stall < req_stall) begin
                    mem_req_ready = 1'b0;
                    stall++;
                    step();
                    n++;
                end else begin
                    mem_req_ready = 1'b1;
                    step();
                    n++;
                    mem_req_ready = 1'b0;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_read(cur);
                    step();
                    n++;
                    mem_rsp_valid = 1'b0;
                    stall = 0;
                end
            end else begin
                step();
                n++;
            end
        end
        obs_timeout = !fill_valid;
        obs_latency = n;
        obs_vpn     = fill_vpn;
        obs_pcid    = fill_pcid;
        obs_ppn     = fill_ppn;
        obs_fault   = fill_fault;
    endtask

    task automatic finish_fill();
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;
    endtask

    task automatic load_basic_tables();
        mem.delete();
        mem[64'h100000] = 64'h201001;
        mem[64'h201000] = 64'h202001;
        mem[64'h202000] = 64'h203001;
        mem[64'h203008] = 64'h5555003;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_miss_ready: got %b expected 1", miss_ready);
        end
        checks++;
        if (mem_req_valid !== 1'b0 || fill_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valids: got req=%b fill=%b expected 0 0", mem_req_valid, fill_valid);
        end
        checks++;
        if (mem_req_addr !== 64'h0 || fill_ppn !== 52'h0 || fill_vpn !== 52'h0 ||
            fill_pcid !== 12'h0 || fill_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr=%h ppn=%h vpn=%h pcid=%h fault=%b expected all 0",
                     mem_req_addr, fill_ppn, fill_vpn, fill_pcid, fill_fault);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_walk();
        load_basic_tables();
        model_walk(52'h1, 52'h100);
        applyStimulus(52'h1, 12'habc, 52'h100, 0);
        checks++;
        if (obs_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_timeout: fill_valid never seen");
        end
        checks++;
        if (obs_addrs.size() != 4 || exp_addrs.size() != 4) begin
            errors++;
            $display("[TB] FAIL basic_req_count: got %0d expected %0d", obs_addrs.size(), exp_addrs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_addrs[i] !== exp_addrs[i]) begin
                    errors++;
                    $display("[TB] FAIL basic_addr%0d: got %h expected %h", i, obs_addrs[i], exp_addrs[i]);
                end
            end
            checks++;
            if (obs_addrs[3] !== 64'h203008) begin
                errors++;
                $display("[TB] FAIL basic_leaf_addr: got %h expected 203008", obs_addrs[3]);
            end
        end
        checks++;
        if (obs_latency != 9) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected 9", obs_latency);
        end
        checks++;
        if (obs_ppn !== 52'h5555 || obs_ppn !== exp_ppn || obs_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_fill: got ppn=%h fault=%b expected ppn=5555 fault=0", obs_ppn, obs_fault);
        end
        checks++;
        if (obs_vpn !== 52'h1 || obs_pcid !== 12'habc) begin
            errors++;
            $display("[TB] FAIL basic_echo: got vpn=%h pcid=%h expected 1 abc", obs_vpn, obs_pcid);
        end
        finish_fill();
    endtask

    task automatic test_l2_fault();
        load_basic_tables();
        mem[64'h201000] = 64'h0;
        model_walk(52'h1, 52'h100);
        applyStimulus(52'h1, 12'h011, 52'h100, 0);
        checks++;
        if (obs_timeout !== 1'b0 || obs_addrs.size() != 2 || exp_addrs.size() != 2) begin
            errors++;
            $display("[TB] FAIL l2_fault_reqs: got %0d requests timeout=%b expected 2", obs_addrs.size(), obs_timeout);
        end
        checks++;
        if (obs_fault !== 1'b1 || obs_ppn !== 52'h0 || exp_fault !== 1'b1) begin
            errors++;
            $display("[TB] FAIL l2_fault_fill: got fault=%b ppn=%h expected fault=1 ppn=0", obs_fault, obs_ppn);
        end
        finish_fill();
    endtask

    task automatic test_noncanonical();
        load_basic_tables();
        applyStimulus(52'h8000000000, 12'h7ff, 52'h100, 0);
        checks++;
        if (obs_addrs.size() != 0) begin
            errors++;
            $display("[TB] FAIL noncanon_req: got %0d requests expected 0", obs_addrs.size());
        end
        checks++;
        if (obs_latency != 1) begin
            errors++;
            $display("[TB] FAIL noncanon_latency: got %0d expected 1", obs_latency);
        end
        checks++;
        if (obs_fault !== 1'b1 || obs_ppn !== 52'h0 || obs_vpn !== 52'h8000000000) begin
            errors++;
            $display("[TB] FAIL noncanon_fill: got fault=%b ppn=%h vpn=%h expected 1 0 8000000000",
                     obs_fault, obs_ppn, obs_vpn);
        end
        finish_fill();
    endtask

    task automatic test_req_stall();
        load_basic_tables();
        model_walk(52'h1, 52'h100);
        applyStimulus(52'h1, 12'h123, 52'h100, 3);
        checks++;
        if (obs_unstable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_addr_stable: got unstable=%b expected 0", obs_unstable);
        end
        checks++;
        if (obs_latency != 21) begin
            errors++;
            $display("[TB] FAIL stall_latency: got %0d expected 21", obs_latency);
        end
        checks++;
        if (obs_ppn !== exp_ppn || obs_fault !== exp_fault) begin
            errors++;
            $display("[TB] FAIL stall_fill: got ppn=%h fault=%b expected ppn=%h fault=%b",
                     obs_ppn, obs_fault, exp_ppn, exp_fault);
        end
        finish_fill();
    endtask

    task automatic test_fill_backpressure();
        load_basic_tables();
        applyStimulus(52'h1, 12'h055, 52'h100, 0);
        miss_vpn   = 52'h8000000000;
        miss_pcid  = 12'h0aa;
        miss_valid = 1'b1;
        fill_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (fill_valid !== 1'b1 || fill_ppn !== 52'h5555 || fill_vpn !== 52'h1 || miss_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b ppn=%h vpn=%h miss_ready=%b expected 1 5555 1 0",
                         i, fill_valid, fill_ppn, fill_vpn, miss_ready);
            end
            step();
        end
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;
        checks++;
        if (fill_valid !== 1'b0 || miss_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_accept: got fill=%b miss_ready=%b req=%b expected 0 1 0",
                     fill_valid, miss_ready, mem_req_valid);
        end
        step();
        miss_valid = 1'b0;
        checks++;
        if (fill_valid !== 1'b1 || fill_fault !== 1'b1 || fill_vpn !== 52'h8000000000 || fill_pcid !== 12'h0aa) begin
            errors++;
            $display("[TB] FAIL bp_next_miss: got valid=%b fault=%b vpn=%h pcid=%h expected 1 1 8000000000 0aa",
                     fill_valid, fill_fault, fill_vpn, fill_pcid);
        end
        finish_fill();
    endtask

    task automatic test_reset_mid_walk();
        logic [63:0] cur;
        load_basic_tables();
        miss_vpn   = 52'h1;
        miss_pcid  = 12'h321;
        root_ppn   = 52'h100;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cur = mem_req_addr;
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_read(cur);
            step();
            mem_rsp_valid = 1'b0;
        end
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h202000) begin
            errors++;
            $display("[TB] FAIL midrst_l1_req: got valid=%b addr=%h expected 1 202000", mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (miss_ready !== 1'b1 || mem_req_valid !== 1'b0 || fill_valid !== 1'b0 ||
            mem_req_addr !== 64'h0 || fill_vpn !== 52'h0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got miss_ready=%b req=%b fill=%b addr=%h vpn=%h expected 1 0 0 0 0",
                     miss_ready, mem_req_valid, fill_valid, mem_req_addr, fill_vpn);
        end
        #2;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h203001;
        step();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (miss_ready !== 1'b1 || mem_req_valid !== 1'b0 || fill_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_idle%0d: got miss_ready=%b req=%b fill=%b expected 1 0 0",
                         i, miss_ready, mem_req_valid, fill_valid);
            end
            step();
        end
    endtask

    // Random tables with occasional bad entries; garbage in the software bits
    task automatic build_random_tables(input logic [51:0] vpn, input logic [51:0] root);
        logic [51:0] tbl;
        logic [51:0] nxt;
        logic [63:0] a;
        logic [11:0] flags;
        int r;
        mem.delete();
        tbl = root;
        for (int lvl = 3; lvl >= 0; lvl--) begin
            a   = {tbl, 12'h000} + 64'((longint'(vpn >> (9 * lvl)) % 512) * 8);
            nxt = 52'($urandom_range(1, 32'hffffff));
            r   = $urandom_range(0, 11);
            if (r == 0)      flags = 12'h000;
            else if (r == 1) flags = (lvl == 0) ? 12'h001 : 12'h003;
            else             flags = (lvl == 0) ? 12'h003 : 12'h001;
            flags = flags | (12'($urandom) & 12'hffc);
            mem[a] = {nxt, flags};
            tbl = nxt;
        end
    endtask

    task automatic checkOutput(input int trial);
        checks++;
        if (obs_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand%0d_timeout: fill_valid never seen", trial);
        end
        checks++;
        if (obs_addrs.size() != exp_addrs.size()) begin
            errors++;
            $display("[TB] FAIL rand%0d_req_count: got %0d expected %0d", trial, obs_addrs.size(), exp_addrs.size());
        end else begin
            for (int i = 0; i < exp_addrs.size(); i++) begin
                checks++;
                if (obs_addrs[i] !== exp_addrs[i]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_addr%0d: got %h expected %h", trial, i, obs_addrs[i], exp_addrs[i]);
                end
            end
        end
        checks++;
        if (obs_ppn !== exp_ppn || obs_fault !== exp_fault) begin
            errors++;
            $display("[TB] FAIL rand%0d_fill: got ppn=%h fault=%b expected ppn=%h fault=%b",
                     trial, obs_ppn, obs_fault, exp_ppn, exp_fault);
        end
    endtask

    task automatic test_random_walks();
        logic [51:0] vpn;
        logic [51:0] root;
        logic [11:0] pcid;
        for (int t = 0; t < 24; t++) begin
            root = 52'($urandom_range(1, 32'hfffff));
            pcid = 12'($urandom);
            vpn  = {20'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) begin
                vpn[40] = 1'b1;
                vpn[35] = 1'b0;
            end else begin
                vpn[51:36] = {16{vpn[35]}};
            end
            build_random_tables(vpn, root);
            model_walk(vpn, root);
            applyStimulus(vpn, pcid, root, $urandom_range(0, 2));
            checkOutput(t);
            checks++;
            if (obs_vpn !== vpn || obs_pcid !== pcid) begin
                errors++;
                $display("[TB] FAIL rand%0d_echo: got vpn=%h pcid=%h expected vpn=%h pcid=%h",
                         t, obs_vpn, obs_pcid, vpn, pcid);
            end
            finish_fill();
        end
    endtask

    // Test sequence
    initial begin
        rst           = 1'b1;
        root_ppn      = '0;
        miss_valid    = 1'b0;
        miss_vpn      = '0;
        miss_pcid     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        fill_ready    = 1'b0;
        test_reset();
        test_basic_walk();
        test_l2_fault();
        test_noncanonical();
        test_req_stall();
        test_fill_backpressure();
        test_reset_mid_walk();
        test_random_walks();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
